// File: rtl/syscall_issuer_if.sv
// Syscall issuer bus: execute-stage request side,
// responder load return, and issuer status outputs.
interface syscall_issuer_if;
  logic        req;
  logic [15:0] code;
  logic [15:0] arg0;
  logic [15:0] arg1;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic        result_valid;
  logic        error;
  logic        halted;
  logic        sys_signal;
  logic [47:0] sysregs;
  logic        load_signal;
  logic [15:0] load_data;

  modport master (
    output req, code, arg0, arg1,
    output load_signal, load_data,
    input  busy, done, result, result_valid,
    input  error, halted, sys_signal, sysregs
  );

  modport slave (
    input  req, code, arg0, arg1,
    input  load_signal, load_data,
    output busy, done, result, result_valid,
    output error, halted, sys_signal, sysregs
  );
endinterface

// File: rtl/syscall_issuer.sv
// Syscall issuer: latches a request, strobes the responder,
// waits for load data when needed, and reports completion.
module syscall_issuer #(
  parameter int debug      = 0,
  parameter int SIG_CYCLES = 2,
  parameter int TIMEOUT    = 255
) (
  input logic clk,
  input logic clear,
  syscall_issuer_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, ASSERT, GAP, WAIT_LOAD, DONE, HALT
  } state_t;

  localparam logic [3:0] SIG_LAST = 4'(SIG_CYCLES - 1);
  localparam logic [7:0] TO_LAST  = 8'(TIMEOUT - 1);

  state_t      state, state_n;
  logic [3:0]  sig_cnt;
  logic [7:0]  wait_cnt;
  logic [47:0] regs;
  logic [15:0] res;
  logic        res_v, err;
  logic        accept, capture, tmo;
  logic        is_load, is_halt;

  // debug only selects simulation tracing elsewhere
  if (debug != 0) begin : g_dbg
  end

  assign is_halt = (regs[15:0] == 16'd0);
  assign is_load = (regs[15:0] == 16'd2) ||
                   (regs[15:0] == 16'd9) ||
                   (regs[15:0] == 16'd10);

  // state register
  always_ff @(posedge clk) begin
    if (clear) state <= IDLE;
    else       state <= state_n;
  end

  // next-state and step decisions
  always_comb begin
    state_n = state;
    accept  = 1'b0;
    capture = 1'b0;
    tmo     = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.req) begin
          accept  = 1'b1;
          state_n = ASSERT;
        end
      end
      ASSERT: begin
        if (sig_cnt == SIG_LAST) begin
          if (is_halt)      state_n = HALT;
          else if (is_load) state_n = WAIT_LOAD;
          else              state_n = GAP;
        end
      end
      GAP: state_n = DONE;
      WAIT_LOAD: begin
        if (wait_cnt != 8'd0 && bus.load_signal) begin
          capture = 1'b1;
          state_n = DONE;
        end else if (wait_cnt == TO_LAST) begin
          tmo     = 1'b1;
          state_n = DONE;
        end
      end
      DONE: state_n = IDLE;
      HALT: state_n = HALT;
      default: state_n = IDLE;
    endcase
  end

  // counters, latched request and load result
  always_ff @(posedge clk) begin
    if (clear) begin
      sig_cnt  <= '0;
      wait_cnt <= '0;
      regs     <= '0;
      res      <= '0;
      res_v    <= 1'b0;
      err      <= 1'b0;
    end else begin
      sig_cnt  <= (state == ASSERT) ? sig_cnt + 4'd1 : 4'd0;
      wait_cnt <= (state == WAIT_LOAD) ? wait_cnt + 8'd1 : 8'd0;
      if (accept) begin
        regs  <= {bus.arg1, bus.arg0, bus.code};
        res_v <= 1'b0;
        err   <= 1'b0;
      end
      if (capture) begin
        res   <= bus.load_data;
        res_v <= 1'b1;
        err   <= 1'b0;
      end
      if (tmo) begin
        res   <= 16'hFFFF;
        res_v <= 1'b0;
        err   <= 1'b1;
      end
    end
  end

  assign bus.busy         = (state != IDLE);
  assign bus.done         = (state == DONE);
  assign bus.sys_signal   = (state == ASSERT);
  assign bus.halted       = (state == HALT);
  assign bus.result       = res;
  assign bus.result_valid = res_v;
  assign bus.error        = err;
  assign bus.sysregs      = regs;

endmodule

// File: tb/tb_syscall_issuer.sv
// Randomized scoreboard bench for syscall_issuer with a
// cycle-level reference model of syscall completions.
module tb_syscall_issuer;
  localparam int S  = 2;
  localparam int TO = 8;

  typedef struct {
    int          cyc;
    logic [15:0] res;
    logic        rv;
    logic        err;
    logic [47:0] regs;
  } exp_t;

  logic clk = 1'b0;
  logic clear;
  int   cyc = 0;
  int   total = 0;
  int   passed = 0;
  exp_t sb[$];

  logic [15:0] m_res;
  logic        m_rv, m_err;

  syscall_issuer_if bus ();

  syscall_issuer #(
    .debug(0),
    .SIG_CYCLES(S),
    .TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .clear(clear),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic bit load_code(input logic [15:0] c);
    return c == 16'd2 || c == 16'd9 || c == 16'd10;
  endfunction

  // monitor: scoreboard pops, done/busy rule, strobe shape
  bit prev_done = 0;
  int hi_run = 0;
  int lo_run = 0;
  bit had = 0;
  always @(negedge clk) begin
    if (prev_done) begin
      chk("busy after done", {62'd0, bus.busy, bus.done}, 64'd0);
    end
    prev_done = bus.done;
    if (bus.done) begin
      if (sb.size() == 0) begin
        chk("unexpected done", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("done cycle", 64'(cyc), 64'(e.cyc));
        chk("result", 64'(bus.result), 64'(e.res));
        chk("result_valid", 64'(bus.result_valid), 64'(e.rv));
        chk("error", 64'(bus.error), 64'(e.err));
        chk("sysregs", 64'(bus.sysregs), 64'(e.regs));
      end
    end
    if (bus.sys_signal) begin
      if (had && lo_run > 0)
        chk("strobe gap>=2", 64'(lo_run >= 2), 64'd1);
      lo_run = 0;
      hi_run++;
      had = 1;
    end else begin
      if (hi_run > 0) chk("strobe length", 64'(hi_run), 64'(S));
      hi_run = 0;
      lo_run++;
    end
  end

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (bus.busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("idle timeout", 64'd1, 64'd0);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!bus.done && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (n >= 60) chk("done timeout", 64'd1, 64'd0);
  endtask

  function automatic exp_t model(input int a,
                                 input logic [15:0] c,
                                 input logic [15:0] x0,
                                 input logic [15:0] x1,
                                 input int k,
                                 input logic [15:0] d);
    exp_t e;
    int ke;
    ke = (k < 1) ? 1 : k;
    m_rv  = 1'b0;
    m_err = 1'b0;
    e.cyc = a + S + 2;
    if (load_code(c)) begin
      if (ke <= TO - 1) begin
        e.cyc = a + S + 2 + ke;
        m_res = d;
        m_rv  = 1'b1;
      end else begin
        e.cyc = a + S + 1 + TO;
        m_res = 16'hFFFF;
        m_err = 1'b1;
      end
    end
    e.res  = m_res;
    e.rv   = m_rv;
    e.err  = m_err;
    e.regs = {x1, x0, c};
    return e;
  endfunction

  task automatic do_op(input logic [15:0] c,
                       input logic [15:0] x0,
                       input logic [15:0] x1,
                       input int k,
                       input logic [15:0] d);
    int a;
    int ld;
    wait_idle();
    bus.req  = 1'b1;
    bus.code = c;
    bus.arg0 = x0;
    bus.arg1 = x1;
    a = cyc;
    sb.push_back(model(a, c, x0, x1, k, d));
    @(negedge clk);
    bus.req = 1'b0;
    ld = a + S + 1 + k;
    if (load_code(c) && ((k < 1) ? 1 : k) <= TO - 1) begin
      while (cyc < ld) @(negedge clk);
      bus.load_signal = 1'b1;
      bus.load_data   = d;
    end
    wait_done();
    bus.load_signal = 1'b0;
    bus.load_data   = 16'h0;
  endtask

  function automatic logic [15:0] rnd_code();
    logic [15:0] t [8];
    t = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd8,
          16'd9, 16'd10, 16'd0};
    t[7] = 16'($urandom_range(11, 65535));
    return t[$urandom_range(0, 7)];
  endfunction

  task automatic check_zero(input string nm);
    chk(nm, {bus.busy, bus.done, bus.result_valid,
             bus.error, bus.halted, bus.sys_signal,
             10'd0, bus.result, bus.sysregs[31:0]},
        64'd0);
    chk({nm, " regs"}, 64'(bus.sysregs), 64'd0);
  endtask

  initial begin
    int a;
    int nd;
    clear           = 1'b1;
    bus.req         = 1'b0;
    bus.code        = '0;
    bus.arg0        = '0;
    bus.arg1        = '0;
    bus.load_signal = 1'b0;
    bus.load_data   = '0;
    m_res = '0;
    m_rv  = 1'b0;
    m_err = 1'b0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    clear = 1'b0;

    do_op(16'd4, 16'd65, 16'd0, 0, 16'd0);
    do_op(16'd2, 16'h0100, 16'd7, 1, 16'hBEEF);
    do_op(16'd9, 16'h0200, 16'd0, 20, 16'd0);
    do_op(16'd10, 16'h0300, 16'd1, 0, 16'h1234);
    do_op(16'd2, 16'h0400, 16'd2, TO - 1, 16'h5A5A);
    do_op(16'd6, 16'h0500, 16'd3, 0, 16'd0);

    // halt, ignored requests, clear with simultaneous req
    wait_idle();
    bus.req  = 1'b1;
    bus.code = 16'd0;
    bus.arg0 = 16'h0033;
    bus.arg1 = 16'h0044;
    a = cyc;
    @(negedge clk);
    bus.req = 1'b0;
    while (cyc < a + S + 1) @(negedge clk);
    chk("halted", 64'(bus.halted), 64'd1);
    bus.req  = 1'b1;
    bus.code = 16'd5;
    repeat (4) @(negedge clk);
    chk("halt busy", {62'd0, bus.busy, bus.sys_signal},
        64'd2);
    chk("halt regs", 64'(bus.sysregs),
        64'(48'h0044_0033_0000));
    clear = 1'b1;
    @(negedge clk);
    check_zero("clear halt");
    clear   = 1'b0;
    bus.req = 1'b0;
    @(negedge clk);
    chk("clear beats req", {63'd0, bus.busy}, 64'd0);
    m_res = '0;
    m_rv  = 1'b0;
    m_err = 1'b0;

    // clear in the middle of WAIT_LOAD
    bus.req  = 1'b1;
    bus.code = 16'd2;
    bus.arg0 = 16'h0100;
    bus.arg1 = 16'h0000;
    a = cyc;
    @(negedge clk);
    bus.req = 1'b0;
    while (cyc < a + S + 2) @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    check_zero("clear wait_load");
    clear = 1'b0;
    do_op(16'd8, 16'h0011, 16'h0022, 0, 16'd0);

    // back-to-back with req held high
    do_op(16'd2, 16'h0700, 16'd0, 2, 16'hCAFE);
    wait_idle();
    bus.req  = 1'b1;
    bus.code = 16'd3;
    bus.arg0 = 16'h0009;
    bus.arg1 = 16'h000A;
    a = cyc;
    sb.push_back(model(a, 16'd3, 16'h9, 16'hA, 0, 16'd0));
    sb.push_back(model(a + S + 3, 16'd3, 16'h9, 16'hA,
                       0, 16'd0));
    nd = 0;
    for (int n = 0; n < 40 && nd < 2; n++) begin
      @(negedge clk);
      if (bus.done) nd++;
    end
    bus.req = 1'b0;
    chk("b2b dones", 64'(nd), 64'd2);

    for (int i = 0; i < 30; i++) begin
      logic [15:0] c;
      c = rnd_code();
      if (c == 16'd0) c = 16'd1;
      do_op(c, 16'($urandom), 16'($urandom),
            int'($urandom_range(0, 10)), 16'($urandom));
    end

    repeat (5) @(negedge clk);
    chk("scoreboard empty", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
